// File: rtl/cpu_obi_decoupler_if.sv
// cpu_obi_decoupler_if: OBI request/response channel; the master issues requests, the slave grants and responds
interface cpu_obi_decoupler_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    req, gnt, we, rvalid, err;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [DATA_WIDTH/8-1:0] be;
   logic [DATA_WIDTH-1:0]   wdata, rdata;
   modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
   modport slave (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/cpu_obi_decoupler.sv
// cpu_obi_decoupler: OBI timing cut with request FIFO, registered responses, credit cap and drain handshake
module cpu_obi_decoupler #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int REQ_DEPTH       = 2,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 drain_req_i,
   output logic                                 drain_ack_o,
   output logic                                 protocol_err_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
   cpu_obi_decoupler_if.slave                   core,
   cpu_obi_decoupler_if.master                  bus
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = REQ_DEPTH > 1 ? $clog2(REQ_DEPTH) : 1;
   localparam int FW = $clog2(REQ_DEPTH + 1);
   typedef enum logic [1:0] {RUN, DRAIN, IDLE} state_t;
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   addr;
      logic                    we;
      logic [DATA_WIDTH/8-1:0] be;
      logic [DATA_WIDTH-1:0]   wdata;
   } req_t;
   state_t        state, state_nxt;
   req_t          mem [REQ_DEPTH];
   req_t          head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] fill;
   logic [CW-1:0] cnt;
   logic          rvalid_q, push, pop, full, empty, accept;
   assign full  = fill == FW'(REQ_DEPTH);
   assign empty = fill == '0;
   // rst_ni gating keeps the grant low while reset is held, not just after it
   assign core.gnt      = rst_ni && state == RUN && !full && cnt < CW'(MAX_OUTSTANDING);
   assign push          = core.req && core.gnt;
   assign pop           = bus.req && bus.gnt;
   assign head          = mem[rd_ptr];
   assign bus.req       = !empty;
   assign bus.addr      = head.addr;
   assign bus.we        = head.we;
   assign bus.be        = head.be;
   assign bus.wdata     = head.wdata;
   assign core.rvalid   = rvalid_q;
   assign outstanding_o = cnt;
   assign drain_ack_o   = state == IDLE;
   // a response is only legitimate if some granted transaction still awaits its core rvalid
   assign accept = bus.rvalid && cnt != CW'(rvalid_q);
   always_comb begin
      state_nxt = state;
      if (state == RUN && drain_req_i) state_nxt = DRAIN;
      else if (state != RUN && !drain_req_i) state_nxt = RUN;
      else if (state == DRAIN && cnt == '0 && empty && !rvalid_q) state_nxt = IDLE;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state          <= RUN;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fill           <= '0;
         cnt            <= '0;
         rvalid_q       <= 1'b0;
         core.rdata     <= '0;
         core.err       <= 1'b0;
         protocol_err_o <= 1'b0;
         for (int i = 0; i < REQ_DEPTH; i++) mem[i] <= '0;
      end else begin
         state <= state_nxt;
         if (push) begin
            mem[wr_ptr] <= '{core.addr, core.we, core.be, core.wdata};
            wr_ptr      <= wr_ptr == PW'(REQ_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr == PW'(REQ_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         fill     <= fill + FW'(push) - FW'(pop);
         cnt      <= cnt + CW'(push) - CW'(rvalid_q);
         rvalid_q <= accept;
         if (accept) begin
            core.rdata <= bus.rdata;
            core.err   <= bus.err;
         end
         if (bus.rvalid && !accept) protocol_err_o <= 1'b1;
      end
   end
endmodule

// File: tb/tb_cpu_obi_decoupler.sv
// tb_cpu_obi_decoupler: directed vectors, corner-case sequences and random traffic against a queue-based reference model
module tb_cpu_obi_decoupler;
   localparam int DEPTH = 2, MAXO = 2;
   localparam int RUNNING = 0, DRAINING = 1, QUIET = 2;
   typedef struct {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} req_t;
   typedef struct {int due; logic [31:0] d; logic e;} rsp_t;
   typedef struct packed {logic req, bg, brv, drn, gnt, breq, rv; logic [1:0] out; logic ack;} vec_t;
   logic clk = 0, rst_n = 0, drain_req = 0, drain_ack, perr;
   logic [1:0] outstanding;
   cpu_obi_decoupler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) core_if ();
   cpu_obi_decoupler_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();
   cpu_obi_decoupler #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .REQ_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
      .clk_i(clk), .rst_ni(rst_n), .drain_req_i(drain_req), .drain_ack_o(drain_ack),
      .protocol_err_o(perr), .outstanding_o(outstanding), .core(core_if), .bus(bus_if));
   always #5 clk = ~clk;
   int tests = 0, fails = 0, cyc = 0, lat_min = 1, lat_max = 4;
   req_t mq[$];
   rsp_t rq[$];
   int m_cnt, m_mode;
   logic m_rv, m_err, m_perr;
   logic [31:0] m_rdata;
   vec_t tbl [15];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      rq.delete();
      m_cnt = 0; m_mode = RUNNING; m_rv = 0; m_err = 0; m_perr = 0; m_rdata = 0;
   endtask

   function automatic logic e_gnt();
      return rst_n && m_mode == RUNNING && mq.size() < DEPTH && m_cnt < MAXO;
   endfunction

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   // rv < 0: the bus responder answers from its queue; otherwise rv is forced onto bus rvalid
   task automatic drive(input logic req, input logic bg, input logic drn, input int rv);
      core_if.req = req;
      core_if.addr = $urandom;
      core_if.we = 1'($urandom_range(0, 1));
      core_if.be = 4'($urandom_range(0, 15));
      core_if.wdata = $urandom;
      bus_if.gnt = bg;
      drain_req = drn;
      bus_if.rdata = $urandom;
      bus_if.err = 1'($urandom_range(0, 1));
      if (rv >= 0) bus_if.rvalid = rv[0];
      else if (rq.size() > 0 && rq[0].due <= cyc) begin
         bus_if.rvalid = 1;
         bus_if.rdata = rq[0].d;
         bus_if.err = rq[0].e;
      end else bus_if.rvalid = 0;
      #1;
   endtask

   task automatic check_model();
      chk("core_gnt", core_if.gnt, e_gnt());
      chk("bus_req", bus_if.req, mq.size() > 0);
      if (mq.size() > 0) begin
         chk("bus_addr", bus_if.addr, mq[0].addr);
         chk("bus_we", bus_if.we, mq[0].we);
         chk("bus_be", bus_if.be, mq[0].be);
         chk("bus_wdata", bus_if.wdata, mq[0].wdata);
      end
      chk("core_rvalid", core_if.rvalid, m_rv);
      chk("core_rdata", core_if.rdata, m_rdata);
      chk("core_err", core_if.err, m_err);
      chk("protocol_err", perr, m_perr);
      chk("drain_ack", drain_ack, m_mode == QUIET);
      chk("outstanding", outstanding, m_cnt);
   endtask

   task automatic advance();
      logic push, pop, spur;
      push = core_if.req && e_gnt();
      pop = mq.size() > 0 && bus_if.gnt;
      spur = bus_if.rvalid && m_cnt == int'(m_rv);
      if (m_mode == RUNNING && drain_req) m_mode = DRAINING;
      else if (m_mode != RUNNING && !drain_req) m_mode = RUNNING;
      else if (m_mode == DRAINING && m_cnt == 0 && mq.size() == 0 && !m_rv) m_mode = QUIET;
      if (bus_if.rvalid && !spur && rq.size() > 0) void'(rq.pop_front());
      if (pop) begin
         rq.push_back('{cyc + $urandom_range(lat_min, lat_max), $urandom, $urandom_range(0, 7) == 0});
         void'(mq.pop_front());
      end
      if (push) mq.push_back('{core_if.addr, core_if.we, core_if.be, core_if.wdata});
      m_cnt += int'(push) - int'(m_rv);
      m_rv = bus_if.rvalid && !spur;
      if (m_rv) begin
         m_rdata = bus_if.rdata;
         m_err = bus_if.err;
      end
      if (spur) m_perr = 1;
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      logic [31:0] a0;
      logic d;
      int n;
      // {req bg brv drn} {gnt breq rv} outstanding ack : credit cap, then drain with two in flight
      tbl[0]  = {4'b1100, 3'b100, 2'd0, 1'b0};
      tbl[1]  = {4'b1100, 3'b110, 2'd1, 1'b0};
      tbl[2]  = {4'b1100, 3'b010, 2'd2, 1'b0};
      tbl[3]  = {4'b1110, 3'b000, 2'd2, 1'b0};
      tbl[4]  = {4'b1100, 3'b001, 2'd2, 1'b0};
      tbl[5]  = {4'b1100, 3'b100, 2'd1, 1'b0};
      tbl[6]  = {4'b0011, 3'b010, 2'd2, 1'b0};
      tbl[7]  = {4'b0101, 3'b011, 2'd2, 1'b0};
      tbl[8]  = {4'b0101, 3'b000, 2'd1, 1'b0};
      tbl[9]  = {4'b0111, 3'b000, 2'd1, 1'b0};
      tbl[10] = {4'b0101, 3'b001, 2'd1, 1'b0};
      tbl[11] = {4'b0101, 3'b000, 2'd0, 1'b0};
      tbl[12] = {4'b0101, 3'b000, 2'd0, 1'b1};
      tbl[13] = {4'b1100, 3'b000, 2'd0, 1'b1};
      tbl[14] = {4'b1100, 3'b100, 2'd0, 1'b0};
      core_if.req = 0; core_if.addr = 0; core_if.we = 0; core_if.be = 0; core_if.wdata = 0;
      bus_if.gnt = 0; bus_if.rvalid = 0; bus_if.rdata = 0; bus_if.err = 0;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(tbl[i].req, tbl[i].bg, tbl[i].drn, int'(tbl[i].brv));
         check_model();
         chk($sformatf("vec%0d_gnt", i), core_if.gnt, tbl[i].gnt);
         chk($sformatf("vec%0d_bus_req", i), bus_if.req, tbl[i].breq);
         chk($sformatf("vec%0d_rvalid", i), core_if.rvalid, tbl[i].rv);
         chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].out);
         chk($sformatf("vec%0d_ack", i), drain_ack, tbl[i].ack);
         advance();
      end
      // back-to-back reads with a fixed two-cycle bus response
      do_reset();
      lat_min = 2; lat_max = 2;
      for (int i = 0; i < 30; i++) begin
         drive(1, 1, 0, -1);
         check_model();
         advance();
      end
      // bus stall for five cycles
      do_reset();
      n = 0;
      a0 = 0;
      for (int i = 0; i < 25; i++) begin
         drive(1, i >= 5, 0, -1);
         check_model();
         if (i == 1) a0 = bus_if.addr;
         if (i > 1 && i < 5) chk("stall_addr_stable", bus_if.addr, a0);
         if (i < 5) n += int'(core_if.gnt);
         if (i == 4) chk("stall_grants", n, DEPTH);
         advance();
      end
      // spurious response with nothing outstanding
      do_reset();
      drive(0, 0, 0, 1);
      check_model();
      advance();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0);
         check_model();
         chk("spur_no_rvalid", core_if.rvalid, 0);
         chk("spur_sticky", perr, 1);
         advance();
      end
      do_reset();
      drive(0, 0, 0, 0);
      check_model();
      chk("spur_cleared", perr, 0);
      advance();
      // asynchronous reset with a full FIFO and two outstanding
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0);
         check_model();
         advance();
      end
      drive(1, 0, 0, 0);
      check_model();
      chk("pre_reset_out", outstanding, 2);
      #2 rst_n = 0;
      #1;
      chk("rst_gnt", core_if.gnt, 0);
      chk("rst_bus_req", bus_if.req, 0);
      chk("rst_bus_addr", bus_if.addr, 0);
      chk("rst_bus_wdata", bus_if.wdata, 0);
      chk("rst_bus_be_we", {bus_if.be, bus_if.we}, 0);
      chk("rst_rvalid", core_if.rvalid, 0);
      chk("rst_rdata_err", {core_if.rdata, core_if.err}, 0);
      chk("rst_flags", {perr, drain_ack}, 0);
      chk("rst_outstanding", outstanding, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      drive(0, 0, 0, -1);
      check_model();
      chk("post_reset_gnt", core_if.gnt, 1);
      advance();
      // random traffic with occasional drain requests
      do_reset();
      lat_min = 1; lat_max = 4;
      d = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) d = !d;
         drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), d, -1);
         check_model();
         chk("cap", outstanding <= MAXO, 1);
         advance();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
